// File: rtl/programmable_delay_stage.sv
// Programmable delay line for ce-qualified sample streams: circular buffer read at
// a runtime-selected distance behind the write pointer, plus a data-aligned divided ce.
module programmable_delay_stage #(
    parameter int WIDTH  = 14,
    parameter int DEPTH  = 16,
    parameter int CE_DIV = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     ce_i,
    input  logic                     data_valid_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic [$clog2(DEPTH)-1:0] delay_i,
    output logic                     data_valid_o,
    output logic                     ce_o,
    output logic [WIDTH-1:0]         data_o,
    output logic                     flush_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST      = CW'(CE_DIV - 1);
    localparam logic [CW-1:0] CNT_AFTER_OUT = (CE_DIV == 1) ? CW'(0) : CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_delay_q;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_data_o;
    logic             r_data_valid_o;
    logic             r_ce_o;
    logic             r_flush_o;

    logic [AW-1:0]    w_rd_ptr;
    logic             w_change;
    logic             w_sel_valid;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_emit;
    logic [DEPTH-1:0] w_valid_next;
    logic [CW-1:0]    w_cnt_next;

    assign w_rd_ptr = r_wr_ptr - r_delay_q;
    assign w_change = (delay_i != r_delay_q);

    // Delay 0 bypasses the buffer; otherwise the read happens before this tick's write.
    always_comb begin
        w_sel_valid = data_valid_i;
        w_sel_data  = data_i;
        if (r_delay_q != '0) begin
            w_sel_valid = r_valid[w_rd_ptr];
            w_sel_data  = r_mem[w_rd_ptr];
        end
    end

    assign w_emit = ce_i & ~w_change & w_sel_valid;

    // A flush drops everything except the sample entering on the change tick.
    always_comb begin
        w_valid_next = r_valid;
        if (w_change) begin
            w_valid_next = '0;
        end
        w_valid_next[r_wr_ptr] = data_valid_i;
    end

    always_comb begin
        w_cnt_next = r_cnt + 1'b1;
        if (w_emit) begin
            w_cnt_next = CNT_AFTER_OUT;
        end else if (r_cnt == CNT_LAST) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid        <= '0;
            r_wr_ptr       <= '0;
            r_delay_q      <= '0;
            r_cnt          <= '0;
            r_data_o       <= '0;
            r_data_valid_o <= 1'b0;
            r_ce_o         <= 1'b0;
            r_flush_o      <= 1'b0;
        end else if (ce_i) begin
            r_valid        <= w_valid_next;
            r_wr_ptr       <= r_wr_ptr + 1'b1;
            r_delay_q      <= delay_i;
            r_cnt          <= w_cnt_next;
            r_data_valid_o <= w_emit;
            r_ce_o         <= w_emit | (r_cnt == '0);
            r_flush_o      <= w_change;
            if (w_emit) begin
                r_data_o <= w_sel_data;
            end
        end else begin
            r_data_valid_o <= 1'b0;
            r_ce_o         <= 1'b0;
            r_flush_o      <= 1'b0;
        end
    end

    assign data_valid_o = r_data_valid_o;
    assign ce_o         = r_ce_o;
    assign data_o       = r_data_o;
    assign flush_o      = r_flush_o;
endmodule

// File: tb/tb_programmable_delay_stage.sv
// Directed bench for programmable_delay_stage: a tick-history model pushes expected
// outputs to a scoreboard queue, compared one clk after each ce tick.
module tb_programmable_delay_stage;
    localparam int WIDTH  = 14;
    localparam int DEPTH  = 16;
    localparam int CE_DIV = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             ce_i = 1'b0;
    logic             data_valid_i = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic [3:0]       delay_i = '0;
    logic             data_valid_o;
    logic             ce_o;
    logic [WIDTH-1:0] data_o;
    logic             flush_o;

    programmable_delay_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CE_DIV(CE_DIV)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ce_i         (ce_i),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .delay_i      (delay_i),
        .data_valid_o (data_valid_o),
        .ce_o         (ce_o),
        .data_o       (data_o),
        .flush_o      (flush_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             f;
        logic             c;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Model: a tick t with delay D emits the input of tick t-D, provided that source
    // tick is no older than the most recent flush (or reset).
    int               m_t;
    int               m_flush_t;
    logic [3:0]       m_dq;
    int               m_cnt;
    logic [WIDTH-1:0] m_data;
    logic             hist_v [0:1023];
    logic [WIDTH-1:0] hist_d [0:1023];
    int               n_emitted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_flush_t = 0; m_dq = '0; m_cnt = 0; m_data = '0;
    endtask

    task automatic do_tick(input logic v, input logic [WIDTH-1:0] d,
                           input logic [3:0] dl, input int gap);
        exp_t e, got;
        int s;
        e.v = 1'b0; e.d = m_data; e.f = 1'b0;
        if (dl != m_dq) begin
            e.f = 1'b1;
            m_dq = dl;
            m_flush_t = m_t;
        end else if (m_dq == 0) begin
            e.v = v;
            e.d = d;
        end else begin
            s = m_t - int'(m_dq);
            if (s >= m_flush_t && hist_v[s]) begin
                e.v = 1'b1;
                e.d = hist_d[s];
            end
        end
        hist_v[m_t] = v;
        hist_d[m_t] = d;
        m_t++;
        if (e.v) m_data = e.d;
        else e.d = m_data;
        if (e.v) begin
            e.c = 1'b1;
            m_cnt = 1 % CE_DIV;
        end else begin
            e.c = (m_cnt == 0);
            m_cnt = (m_cnt + 1) % CE_DIV;
        end
        q.push_back(e);

        ce_i = 1'b1; data_valid_i = v; data_i = d; delay_i = dl;
        @(posedge clk_i); #1;
        ce_i = 1'b0; data_valid_i = 1'b1; data_i = WIDTH'($urandom);

        got = q.pop_front();
        if (got.v) n_emitted++;
        check("data_valid_o", {31'd0, data_valid_o}, {31'd0, got.v});
        check("data_o", {18'd0, data_o}, {18'd0, got.d});
        check("flush_o", {31'd0, flush_o}, {31'd0, got.f});
        check("ce_o", {31'd0, ce_o}, {31'd0, got.c});
        for (int g = 0; g < gap; g++) begin
            @(posedge clk_i); #1;
            check("idle_valid", {31'd0, data_valid_o}, 32'd0);
            check("idle_ce", {31'd0, ce_o}, 32'd0);
            check("idle_flush", {31'd0, flush_o}, 32'd0);
            check("idle_data_hold", {18'd0, data_o}, {18'd0, m_data});
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'd0, data_valid_o}, 32'd0);
        check({tag, "_ce"}, {31'd0, ce_o}, 32'd0);
        check({tag, "_flush"}, {31'd0, flush_o}, 32'd0);
        check({tag, "_data"}, {18'd0, data_o}, 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] src [0:39];
        int guard;
        model_reset();
        n_emitted = 0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1 check_zero("reset");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check_zero("post_reset_idle");

        // Delay 0 bypass, ce every 4th clk
        n_emitted = 0;
        for (int i = 1; i <= 3; i++) do_tick(1'b1, WIDTH'(i), 4'd0, 3);
        check("bypass_count", n_emitted, 3);

        // Delay 5, a single sample; only the configuration tick flushes
        do_tick(1'b0, '0, 4'd5, 0);
        for (int i = 0; i < 9; i++) do_tick(1'b0, '0, 4'd5, 0);
        n_emitted = 0;
        do_tick(1'b1, 14'h1AB, 4'd5, 1);
        for (int i = 0; i < 8; i++) do_tick(1'b0, '0, 4'd5, 1);
        check("single_sample_count", n_emitted, 1);

        // Delay 15, 40 back-to-back samples across pointer wrap
        do_tick(1'b0, '0, 4'd15, 0);
        for (int i = 0; i < 15; i++) do_tick(1'b0, '0, 4'd15, 0);
        n_emitted = 0;
        for (int i = 0; i < 40; i++) begin
            src[i] = WIDTH'($urandom);
            do_tick(1'b1, src[i], 4'd15, 0);
        end
        for (int i = 0; i < 16; i++) do_tick(1'b0, '0, 4'd15, 0);
        check("wrap_count", n_emitted, 40);
        check("last_wrap_sample", {18'd0, data_o}, {18'd0, src[39]});

        // Stream at delay 3, switch to 7 mid-stream
        for (int i = 0; i < 20; i++) do_tick(1'b1, WIDTH'(16'h100 + i), 4'd3, 0);
        n_emitted = 0;
        for (int i = 0; i < 7; i++) do_tick(1'b1, WIDTH'(16'h200 + i), 4'd7, 0);
        check("post_change_silence", n_emitted, 0);
        do_tick(1'b1, 14'h0333, 4'd7, 0);
        check("first_after_change", {18'd0, data_o}, 32'h200);
        for (int i = 0; i < 8; i++) do_tick(1'b0, '0, 4'd7, 0);

        // ce_o divider: idle ticks, then inject an output when the counter is 2
        for (int i = 0; i < 9; i++) do_tick(1'b0, '0, 4'd0, 1);
        guard = 0;
        while (m_cnt != 2 && guard < 8) begin
            do_tick(1'b0, '0, 4'd0, 0);
            guard++;
        end
        check("divider_phase_found", {31'd0, guard < 8}, 32'd1);
        do_tick(1'b1, 14'h2A5, 4'd0, 0);
        for (int i = 0; i < 6; i++) do_tick(1'b0, '0, 4'd0, 0);

        // Reset with 4 samples in flight at delay 8
        do_tick(1'b0, '0, 4'd8, 0);
        for (int i = 0; i < 4; i++) do_tick(1'b1, WIDTH'(16'h3C0 + i), 4'd8, 0);
        do_tick(1'b0, '0, 4'd8, 0);
        rst_ni = 1'b0;
        #1 check_zero("mid_reset_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            check_zero("mid_reset");
        end
        rst_ni = 1'b1;
        model_reset();
        n_emitted = 0;
        for (int i = 0; i < 20; i++) do_tick(1'b0, '0, 4'd8, 0);
        check("no_stale_after_reset", n_emitted, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
